// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-serial load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 8;
  localparam int KW     = $clog2(BEATS);

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] a);
    return (a & ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// Request/response and byte-memory bus between core, LSU and data memory.
interface lsu_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// One byte lane: offers its store byte on its beat, captures its load byte.
module lsu_byte_lane import lsu_pkg::*; #(
  parameter int LANE = 0
) (
  input  logic [KW-1:0]     wsel,
  input  logic [BEAT_W-1:0] wbyte_in,
  output logic [BEAT_W-1:0] wbyte,
  input  logic              cap_en,
  input  logic [KW-1:0]     csel,
  input  logic [BEAT_W-1:0] rbyte,
  input  logic [BEAT_W-1:0] asm_q,
  output logic [BEAT_W-1:0] asm_d
);
  localparam logic [KW-1:0] IDX = KW'(LANE);

  // Unselected lanes output zero so the top can OR the lanes together.
  assign wbyte = (wsel == IDX) ? wbyte_in : '0;
  assign asm_d = (cap_en && csel == IDX) ? rbyte : asm_q;
endmodule

// File: rtl/load_store_unit.sv
// Sequences one 32-bit load/store as four byte beats over an 8-bit memory.
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);
  state_e                         state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic                           we_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [DATA_W-1:0]              wdata_q;
  logic [DATA_W-1:0]              rdata_q;
  logic [BEATS-1:0][BEAT_W-1:0]   asm_q, asm_d, wsrc, wlane;
  logic [BEAT_W-1:0]              wor_b;
  logic                           accept, cap_en;
  logic [KW-1:0]                  wsel, csel;
  logic                           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                           mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [BEAT_W-1:0]              mem_wdata_q, mem_wdata_d;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Beat 0 is launched from the request itself on the accept edge.
  assign wsrc = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign wsel = (state_q == IDLE) ? '0 : k_q + KW'(1);

  // Read byte for beat k arrives one cycle later: lane k-1 in ISSUE, lane 3 in DRAIN.
  assign cap_en = (state_q == DRAIN) || (state_q == ISSUE && k_q != '0 && !we_q);
  assign csel   = (state_q == DRAIN) ? KW'(BEATS-1) : k_q - KW'(1);

  for (genvar i = 0; i < BEATS; i++) begin : g_lane
    lsu_byte_lane #(.LANE(i)) u_lane (
      .wsel     (wsel),
      .wbyte_in (wsrc[i]),
      .wbyte    (wlane[i]),
      .cap_en   (cap_en),
      .csel     (csel),
      .rbyte    (bus.mem_rdata),
      .asm_q    (asm_q[i]),
      .asm_d    (asm_d[i])
    );
  end

  always_comb begin
    wor_b = '0;
    for (int i = 0; i < BEATS; i++) wor_b |= wlane[i];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        if (misaligned(bus.req_addr[1:0])) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d    = ISSUE;
          k_d        = '0;
          mem_en_d   = 1'b1;
          mem_we_d   = bus.req_we;
          mem_addr_d = bus.req_addr;
        end
      end
      ISSUE: if (k_q == KW'(BEATS-1)) begin
        state_d     = we_q ? IDLE : DRAIN;
        rsp_valid_d = we_q;
      end else begin
        k_d        = k_q + KW'(1);
        mem_en_d   = 1'b1;
        mem_we_d   = we_q;
        mem_addr_d = addr_q + ADDR_W'(wsel);
      end
      DRAIN: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    mem_wdata_d = (mem_en_d && mem_we_d) ? wor_b : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      asm_q <= asm_d;
      if (state_q == DRAIN) rdata_q <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(8), .DATA_W(32)) bus();

  load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory seen by the DUT: 1-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end

  // Reference: word view over a byte array, little-endian.
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata;
  int n_chk  = 0;
  int n_pass = 0;
  int waited;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic xact(input logic we, input logic [7:0] a, input logic [31:0] wd, input bit keep);
    int n, nb, nst, w, exp_lat;
    bit mis;
    logic [7:0] ba [8];
    logic [7:0] bd [8];
    logic       bw [8];
    int         bc [8];
    logic       err;
    logic [31:0] rd;
    logic [7:0] ai;
    mis = (a[1:0] != 2'b00);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    w = 0;
    while (!bus.req_ready && w < 40) begin @(negedge clk); w++; end
    waited = w;
    chk("accept", w < 40, 1);
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
    n = 1; nb = 0; nst = 0; err = 1'b0; rd = '0;
    forever begin
      if (bus.mem_en) begin
        if (nb < 8) begin
          ba[nb] = bus.mem_addr; bd[nb] = bus.mem_wdata; bw[nb] = bus.mem_we; bc[nb] = n;
        end
        nb++;
      end
      if (bus.stall) nst++;
      if (bus.rsp_valid) begin err = bus.rsp_err; rd = bus.rsp_rdata; break; end
      if (n >= 20) break;
      @(negedge clk);
      n++;
    end
    exp_lat = mis ? 1 : (we ? 5 : 6);
    chk("latency", n, exp_lat);
    chk("beat count", nb, mis ? 0 : 4);
    chk("stall cycles", nst, mis ? 0 : exp_lat - 1);
    chk("rsp_err", err, mis);
    if (!mis) begin
      for (int i = 0; i < 4 && i < nb; i++) begin
        ai = a + 8'(i);
        chk("beat addr", ba[i], ai);
        chk("beat cycle", bc[i], i + 1);
        chk("beat we", bw[i], we);
        if (we) begin
          chk("beat wdata", bd[i], wd[8*i +: 8]);
          ref_mem[ai] = wd[8*i +: 8];
        end
      end
      if (!we) exp_rdata = {ref_mem[a+8'd3], ref_mem[a+8'd2], ref_mem[a+8'd1], ref_mem[a]};
    end
    chk("rsp_rdata", rd, exp_rdata);
  endtask

  initial begin
    int cnt;
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    exp_rdata     = '0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", bus.req_ready, 1);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    xact(1'b1, 8'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 8'h10, 32'h0, 0);
    chk("load DEADBEEF", bus.rsp_rdata, 32'hDEADBEEF);
    xact(1'b0, 8'h12, 32'h0, 0);

    // Back-to-back across the top of the address space.
    xact(1'b0, 8'hFC, 32'h0, 1);
    chk("b2b accept slot", {bus.rsp_valid, bus.req_ready}, 2'b11);
    xact(1'b1, 8'h00, 32'hA5C3_1E77, 0);
    chk("b2b no wait", waited, 0);
    xact(1'b0, 8'h00, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      xact(1'($urandom), ra, $urandom, 0);
    end

    // Mid-simulation reset from idle.
    rst = 1'b0;
    #1;
    chk("reset req_ready", bus.req_ready, 1);
    chk("reset stall", bus.stall, 0);
    chk("reset mem_en", bus.mem_en, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_rdata", bus.rsp_rdata, 0);
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Abort a load during beat 2.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort beat2 en", bus.mem_en, 1);
    chk("abort beat2 addr", bus.mem_addr, 8'h12);
    rst = 1'b0;
    #1;
    chk("abort mem_en", bus.mem_en, 0);
    chk("abort mem_we", bus.mem_we, 0);
    chk("abort stall", bus.stall, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("abort no rsp", cnt, 0);
    chk("abort rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("abort idle", bus.req_ready, 1);
    xact(1'b0, 8'h10, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
